beam_power_sort: RTL
====================

// Module: beam_power_sort
// PURPOSE
//  Accumulates per-beam power over one RBG and selects the BEAM strongest of NBEAM beams.
//  Drives i_beam_idx / i_rbg_load of the downstream codeword-selection stage.
//  Insertion top-K: one candidate per cycle into a K-entry sorted list.
//  Accumulation of the next RBG overlaps the sort of the current one.
// PARAMETERS
//  NBEAM  64  total candidate beams (<=256)
//  BEAM   16  beams selected per RBG (K)
//  PWR_W  32  input power width, unsigned
//  ACC_W  40  accumulator width, unsigned, saturating
// PORTS
//  i_clk       in   1            clock
//  i_reset_n   in   1            asynchronous active-low reset
//  i_pwr_vld   in   1            power sample valid
//  i_pwr_beam  in   8            beam id of sample
//  i_pwr       in   PWR_W        power of sample
//  i_rbg_end   in   1            pulse: closes current RBG
//  o_beam_idx  out  BEAM x 8     sorted beam ids; [0] = strongest
//  o_rbg_load  out  1            1-cycle pulse: o_beam_idx updated this cycle
//  o_busy      out  1            sort in progress
//  o_ovf       out  1            1-cycle pulse: RBG result dropped
// BEHAVIOUR
//  Reset values: o_beam_idx[i]=i, o_rbg_load=0, o_busy=0, o_ovf=0; accumulators and list cleared; FSM=IDLE.
//  Accumulate:
//   - i_pwr_vld with i_pwr_beam<NBEAM: acc[beam] += i_pwr (zero-extended).
//   - Sum clamps to 2^ACC_W-1.
//   - i_pwr_beam>=NBEAM: sample ignored.
//  RBG close, i_rbg_end at cycle T:
//   - A sample valid in cycle T belongs to the closing RBG.
//   - snap[] <= acc (incl. that sample); acc[] <= 0 at T+1.
//  FSM states:
//   - IDLE -> SORT on i_rbg_end.
//   - SORT: counter n=0..NBEAM-1; candidate (snap[n],n) inserted at T+1+n; o_busy=1.
//   - SORT -> OUT after n=NBEAM-1.
//   - OUT (cycle T+NBEAM+1): o_beam_idx <= list ids; o_rbg_load=1.
//   - OUT -> IDLE. If i_rbg_end is asserted in OUT, it starts a new SORT directly.
//  Insertion rule:
//   - List cleared to invalid at SORT entry; an invalid entry loses to any candidate, including power 0.
//   - Candidate position p = count of valid entries with pwr >= candidate.
//   - Entries p..K-2 shift down one slot; entry K-1 is dropped; p>=K means the candidate is discarded.
//   - Ties: lower beam id ranks higher (ascending scan, >= comparison).
//  Latency: o_rbg_load asserts NBEAM+1 cycles after the i_rbg_end cycle. Minimum RBG spacing NBEAM+1 cycles.
//  Overflow (i_rbg_end during SORT):
//   - o_ovf pulses next cycle.
//   - acc[] of the colliding RBG is cleared, no snapshot; the in-flight sort completes unaffected.
//  o_beam_idx holds its value between loads; ids zero-extended to 8 bits.
//  Reset mid-operation: immediate return to reset values; a pending o_rbg_load is never emitted.
// STRUCTURE
//  Package pusch_dr_pkg:
//   - constants NBEAM_MAX=256, BIDX_W=8
//   - typedef beam_idx_t (logic[7:0])
//   - enum sort_st_e {IDLE,SORT,OUT}
//   - struct topk_ent_t {vld, pwr[ACC_W], idx}
//  Sub-module topk_insert:
//   - K-entry sorted register list.
//   - Ports: clr, cand_vld, cand_pwr, cand_idx, list out.
//   - Parallel compare produces a thermometer mask; shift/insert in 1 cycle.
//  Top level: accumulator bank, snapshot bank, FSM, counter, output registers.
// TESTING
//  1 Reset, no stimulus -> o_beam_idx[i]=i for all i, o_rbg_load=0, o_busy=0.
//  2 Beam b gets i_pwr=10*b once, then i_rbg_end at T ->
//    o_rbg_load at T+65 with o_beam_idx = 63,62,...,48; o_busy high T+1..T+64.
//  3 All 64 beams i_pwr=100 -> o_beam_idx = 0..15 (tie rule).
//  4 Beam 5 gets 300 samples of 32'hFFFF_FFFF (acc clamps to 2^40-1), others 1 ->
//    o_beam_idx[0]=5, others = beams 0..4,6..15 in order.
//  5 i_pwr_vld+i_pwr_beam=7+i_pwr=1000 in the same cycle as i_rbg_end, all others 0 ->
//    o_beam_idx[0]=7; next RBG's acc[7] starts at 0.
//  6 Second i_rbg_end at T+10 -> o_ovf pulse at T+11; first result at T+65 unaffected.
//    Then i_reset_n low at T+30 of a new sort -> no o_rbg_load; o_beam_idx = identity.

Source files
------------

// File: rtl/pusch_dr_pkg.sv
// Shared types and constants for the PUSCH beam-power sorting path.
package pusch_dr_pkg;

    localparam int NBEAM_MAX = 256;
    localparam int BIDX_W    = 8;
    localparam int ACC_W_DEF = 40;

    typedef logic [BIDX_W-1:0] beam_idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        OUT  = 2'd2
    } sort_st_e;

    // One slot of the top-K list; vld=0 marks a slot that loses to any candidate.
    typedef struct packed {
        logic                 vld;
        logic [ACC_W_DEF-1:0] pwr;
        beam_idx_t            idx;
    } topk_ent_t;

endpackage

// File: rtl/beam_power_sort_topk_insert.sv
// K-entry sorted list, one candidate inserted per cycle.
// A parallel compare builds a thermometer mask (ge) of slots that stay ahead of
// the candidate; the first slot not ahead takes the candidate, later slots
// shift down by one, and the last slot falls off. Equal power keeps the
// incumbent ahead, so earlier (lower-id) candidates win ties.
module topk_insert
    import pusch_dr_pkg::*;
#(
    parameter int K = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 cand_vld,
    input  logic [ACC_W_DEF-1:0] cand_pwr,
    input  beam_idx_t            cand_idx,
    output beam_idx_t            list_ids_nxt [K]
);

    topk_ent_t      list     [K];
    topk_ent_t      list_nxt [K];
    topk_ent_t      prev     [K];
    topk_ent_t      cand;
    logic [K-1:0]   ge;
    logic [K-1:0]   ge_up;

    // Compare every slot against the candidate and form the shift sources.
    always_comb begin
        cand     = '{vld: 1'b1, pwr: cand_pwr, idx: cand_idx};
        ge       = '0;
        ge_up    = '0;
        ge_up[0] = 1'b1;
        prev[0]  = cand;
        for (int i = 0; i < K; i++) begin
            ge[i] = list[i].vld && (list[i].pwr >= cand_pwr);
        end
        for (int i = 1; i < K; i++) begin
            ge_up[i] = ge[i-1];
            prev[i]  = list[i-1];
        end
    end

    // Next list: keep, insert, or shift down; clear wins over insertion.
    always_comb begin
        for (int i = 0; i < K; i++) begin
            list_nxt[i]     = list[i];
            if (clr) begin
                list_nxt[i] = '0;
            end else if (cand_vld && !ge[i]) begin
                list_nxt[i] = ge_up[i] ? cand : prev[i];
            end
            list_ids_nxt[i] = list_nxt[i].idx;
        end
    end

    // List register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < K; i++) list[i] <= '0;
        end else begin
            for (int i = 0; i < K; i++) list[i] <= list_nxt[i];
        end
    end

endmodule

// File: rtl/beam_power_sort.sv
// Per-beam power accumulation over an RBG and top-BEAM selection of NBEAM beams.
// Accumulation of the next RBG runs while the previous snapshot is sorted.
// Handshake: i_pwr_vld qualifies i_pwr_beam/i_pwr for exactly the cycle it is
// high (no back-pressure); i_rbg_end is a single-cycle pulse and the sample of
// that cycle belongs to the closing RBG; o_rbg_load is a single-cycle pulse in
// the cycle o_beam_idx first shows the new result.
module beam_power_sort
    import pusch_dr_pkg::*;
#(
    parameter int NBEAM = 64,
    parameter int BEAM  = 16,
    parameter int PWR_W = 32,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_pwr_vld,
    input  logic [7:0]       i_pwr_beam,
    input  logic [PWR_W-1:0] i_pwr,
    input  logic             i_rbg_end,
    output beam_idx_t        o_beam_idx [BEAM],
    output logic             o_rbg_load,
    output logic             o_busy,
    output logic             o_ovf,
    output logic [1:0]       o_state
);

    localparam int             CNT_W   = (NBEAM > 1) ? $clog2(NBEAM) : 1;
    localparam logic [1:0]     ST_IDLE = 2'(IDLE);
    localparam logic [1:0]     ST_SORT = 2'(SORT);
    localparam logic [1:0]     ST_OUT  = 2'(OUT);
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    logic [ACC_W-1:0] acc  [NBEAM];
    logic [ACC_W-1:0] snap [NBEAM];
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             beam_ok;
    logic [CNT_W-1:0] beam_sel;
    logic             hit;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] sum_sat;
    logic             start;
    logic             collide;
    logic             last;
    beam_idx_t        ids_nxt [BEAM];

    // Decode the incoming sample and form its saturated sum.
    always_comb begin
        beam_ok  = ({1'b0, i_pwr_beam} < 9'(NBEAM));
        beam_sel = i_pwr_beam[CNT_W-1:0];
        hit      = i_pwr_vld && beam_ok;
        sum      = {1'b0, acc[beam_sel]} + (ACC_W+1)'(i_pwr);
        sum_sat  = sum[ACC_W] ? ACC_MAX : sum[ACC_W-1:0];
        start    = i_rbg_end && (state != ST_SORT);
        collide  = i_rbg_end && (state == ST_SORT);
        last     = (state == ST_SORT) && (cnt == CNT_W'(NBEAM - 1));
    end

    // Accumulator bank: every RBG close clears it, colliding or not.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int b = 0; b < NBEAM; b++) acc[b] <= '0;
        end else begin
            for (int b = 0; b < NBEAM; b++) begin
                if (i_rbg_end) begin
                    acc[b] <= '0;
                end else if (hit && (beam_sel == CNT_W'(b))) begin
                    acc[b] <= sum_sat;
                end
            end
        end
    end

    // Snapshot bank: captured only when a new sort can start.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int b = 0; b < NBEAM; b++) snap[b] <= '0;
        end else if (start) begin
            for (int b = 0; b < NBEAM; b++) begin
                snap[b] <= (hit && (beam_sel == CNT_W'(b))) ? sum_sat : acc[b];
            end
        end
    end

    // Sort sequencer: IDLE -> SORT (NBEAM cycles) -> OUT -> IDLE or SORT.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_SORT: begin
                    if (last) state <= ST_OUT;
                    else      cnt   <= cnt + 1'b1;
                end
                ST_IDLE, ST_OUT: begin
                    cnt <= '0;
                    state <= start ? ST_SORT : ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    topk_insert #(.K(BEAM)) u_topk (
        .clk          (i_clk),
        .rst_n        (i_reset_n),
        .clr          (start),
        .cand_vld     (state == ST_SORT),
        .cand_pwr     (ACC_W_DEF'(snap[cnt])),
        .cand_idx     (BIDX_W'(cnt)),
        .list_ids_nxt (ids_nxt)
    );

    // Output registers: the final insertion result is loaded on the edge into OUT.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < BEAM; i++) o_beam_idx[i] <= BIDX_W'(i);
            o_rbg_load <= 1'b0;
            o_ovf      <= 1'b0;
        end else begin
            o_rbg_load <= last;
            o_ovf      <= collide;
            if (last) begin
                for (int i = 0; i < BEAM; i++) o_beam_idx[i] <= ids_nxt[i];
            end
        end
    end

    assign o_busy  = (state == ST_SORT);
    assign o_state = state;

endmodule
